// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver, transmitter and their buffers.
package uart_pkg;

  localparam int UART_DATA_W           = 8;
  localparam int FULL_BIT              = 1395968;
  localparam int HALF_BIT              = 697984;
  localparam int DEFAULT_RX_FIFO_DEPTH = 16;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointer and occupancy control for a power-of-two circular buffer.
// The count register disambiguates full from empty when the pointers are equal.
module fifo_ptr_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_ready,
  output logic              wr_en,
  output logic              rd_en,
  output logic              drop,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W:0] count_next;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so a full buffer still accepts a write alongside it.
  assign rd_en = rd_ready && !empty;
  assign wr_en = wr_req && (!full || rd_en);
  assign drop  = wr_req && full && !rd_en;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    unique case ({wr_en, rd_en})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver, with sticky overflow flag.
// Define UART_RX_FIFO_STATS_EN to add the o_drop_count and o_max_count statistics outputs.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_RX_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_wr_valid,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_rd_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  input  logic              i_clear_overflow
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [7:0]        o_drop_count,
  output logic [ADDR_W:0]   o_max_count
`endif
);

  logic              wr_en;
  logic              rd_en;
  logic              drop;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ptr_ctrl (
    .clk      (clk),
    .rst      (i_reset),
    .wr_req   (i_wr_valid),
    .rd_ready (i_rd_ready),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .drop     (drop),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (o_count),
    .full     (o_full),
    .empty    (o_empty)
  );

  // NOTE: storage has no reset; the count makes stale entries invisible, and this lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= i_wr_data;
  end

  assign o_rd_data  = mem[rd_ptr];
  assign o_rd_valid = !o_empty;

  // A drop in the same cycle as a clear keeps the flag set so the loss is never missed.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset)               o_overflow <= 1'b0;
    else if (drop)             o_overflow <= 1'b1;
    else if (i_clear_overflow) o_overflow <= 1'b0;
  end

`ifdef UART_RX_FIFO_STATS_EN
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      o_drop_count <= '0;
      o_max_count  <= '0;
    end else begin
      if (i_clear_overflow)            o_drop_count <= drop ? 8'd1 : 8'd0;
      else if (drop && o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 1'b1;

      if (i_clear_overflow)            o_max_count <= o_count;
      else if (o_count > o_max_count)  o_max_count <= o_count;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo using a byte scoreboard and an occupancy model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_wr_valid;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_rd_valid;
  logic [DATA_W-1:0] o_rd_data;
  logic              i_rd_ready;
  logic [ADDR_W:0]   o_count;
  logic              o_full;
  logic              o_empty;
  logic              o_overflow;
  logic              i_clear_overflow;
`ifdef UART_RX_FIFO_STATS_EN
  logic [7:0]        o_drop_count;
  logic [ADDR_W:0]   o_max_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] q[$];
  int   mcount = 0;
  logic movf   = 1'b0;
  int   mdrop  = 0;
  int   mmax   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk              (clk),
    .i_reset          (i_reset),
    .i_wr_valid       (i_wr_valid),
    .i_wr_data        (i_wr_data),
    .o_rd_valid       (o_rd_valid),
    .o_rd_data        (o_rd_data),
    .i_rd_ready       (i_rd_ready),
    .o_count          (o_count),
    .o_full           (o_full),
    .o_empty          (o_empty),
    .o_overflow       (o_overflow),
    .i_clear_overflow (i_clear_overflow)
`ifdef UART_RX_FIFO_STATS_EN
    ,
    .o_drop_count     (o_drop_count),
    .o_max_count      (o_max_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ":count"},    32'(o_count),    32'(mcount));
    check({tag, ":empty"},    32'(o_empty),    32'(mcount == 0));
    check({tag, ":full"},     32'(o_full),     32'(mcount == DEPTH));
    check({tag, ":rd_valid"}, 32'(o_rd_valid), 32'(mcount != 0));
    check({tag, ":overflow"}, 32'(o_overflow), 32'(movf));
    if (q.size() > 0) check({tag, ":head"}, 32'(o_rd_data), 32'(q[0]));
`ifdef UART_RX_FIFO_STATS_EN
    check({tag, ":drop_count"}, 32'(o_drop_count), 32'(mdrop));
    check({tag, ":max_count"},  32'(o_max_count),  32'(mmax));
`endif
  endtask

  // Drives one clock cycle of stimulus, updates the model, then checks the registered state.
  task automatic cycle(input string tag, input logic wv, input logic [DATA_W-1:0] wd,
                       input logic rr, input logic clr);
    logic hs;
    logic drop;
    int   pre;
    pre  = mcount;
    hs   = rr && (mcount > 0);
    drop = wv && (mcount == DEPTH) && !hs;
    i_wr_valid       = wv;
    i_wr_data        = wd;
    i_rd_ready       = rr;
    i_clear_overflow = clr;
    if (hs) begin
      check({tag, ":pop_data"}, 32'(o_rd_data), 32'(q[0]));
      void'(q.pop_front());
    end
    if (wv && !drop) q.push_back(wd);
    mcount = q.size();
    if (drop)     movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (clr) begin
      mdrop = drop ? 1 : 0;
      mmax  = pre;
    end else begin
      if (drop && mdrop < 255) mdrop++;
      if (pre > mmax) mmax = pre;
    end
    @(posedge clk);
    #1;
    i_wr_valid       = 1'b0;
    i_rd_ready       = 1'b0;
    i_clear_overflow = 1'b0;
    check_state(tag);
  endtask

  task automatic model_reset();
    q.delete();
    mcount = 0;
    movf   = 1'b0;
    mdrop  = 0;
    mmax   = 0;
  endtask

  initial begin
    i_reset          = 1'b1;
    i_wr_valid       = 1'b0;
    i_wr_data        = '0;
    i_rd_ready       = 1'b0;
    i_clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    i_reset = 1'b0;
    @(posedge clk);
    #1;

    // Single byte: visible the cycle after the write, then popped.
    cycle("wr55", 1'b1, 8'h55, 1'b0, 1'b0);
    cycle("rd55", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to full, drain in order, then confirm pointers wrapped cleanly.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("wrap_wr", 1'b1, 8'h77, 1'b0, 1'b0);
    cycle("wrap_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Full: dropped write, write with simultaneous pop, drop racing a clear, clear alone.
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    cycle("dropAA", 1'b1, 8'hAA, 1'b0, 1'b0);
    cycle("full_rw_BB", 1'b1, 8'hBB, 1'b1, 1'b0);
    cycle("drop_clr", 1'b1, 8'hCC, 1'b0, 1'b1);
    cycle("clr_only", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Empty with write and ready together: the read is not a handshake.
    cycle("empty_rw", 1'b1, 8'h5A, 1'b1, 1'b0);
    cycle("rd5A", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between clock edges with five bytes buffered.
    for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
    #3;
    i_reset = 1'b1;
    #1;
    check("async_rst:empty", 32'(o_empty), 32'd1);
    check("async_rst:count", 32'(o_count), 32'd0);
    model_reset();
    @(negedge clk);
    i_reset = 1'b0;
    @(posedge clk);
    #1;
    check_state("post_rst");
    cycle("wr3C", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("rd3C", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each single-cycle byte strobe from the receiver. The receiver has no backpressure, so bytes must be absorbed immediately.
- Holds bytes in a DEPTH-entry circular buffer and presents them to the consumer (command parser / host logic) over a valid/ready interface.
- Flags and counts bytes lost when the buffer is full.

Parameters:
- DEPTH, 16, number of byte entries; power of two, >= 2
- DATA_W, 8, width of one entry (matches receiver byte width)
- ADDR_W, $clog2(DEPTH), derived localparam; pointer width

Ports:
- clk  input  1  single clock, all state on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_wr_valid  input  1  single-cycle strobe from receiver: byte available
- i_wr_data  input  DATA_W  byte from receiver, valid when i_wr_valid=1
- o_rd_valid  output  1  head entry available (= not empty)
- o_rd_data  output  DATA_W  head entry (first-word-fall-through)
- i_rd_ready  input  1  consumer accepts head when o_rd_valid=1
- o_count  output  ADDR_W+1  current occupancy, 0..DEPTH
- o_full  output  1  count == DEPTH
- o_empty  output  1  count == 0
- o_overflow  output  1  sticky: a write was dropped
- i_clear_overflow  input  1  clears o_overflow

Behaviour:
- Reset (async assert, state held while high): wr_ptr=0, rd_ptr=0, count=0, o_overflow=0. Outputs: o_empty=1, o_full=0, o_rd_valid=0, o_count=0. o_rd_data don't-care (storage not cleared).
- Reset mid-operation discards all buffered data. The first write after deassertion lands at entry 0.
- Write accepted when i_wr_valid && (!full || read handshake in same cycle). On accept: mem[wr_ptr]<=i_wr_data, wr_ptr wraps DEPTH-1 -> 0.
- Read handshake = o_rd_valid && i_rd_ready. On handshake, rd_ptr advances with the same wrap rule. i_rd_ready while empty is ignored.
- o_rd_data = mem[rd_ptr] combinationally. Write-to-read latency: a byte written into an empty FIFO appears on o_rd_valid/o_rd_data the next cycle. No same-cycle bypass.
- Count update:
  - +1 on write only
  - -1 on read only
  - unchanged on simultaneous write+read, including when full or empty (empty + write + ready: the read is not a handshake, so count goes +1).
- Full, no read, i_wr_valid=1: byte dropped, pointers/count unchanged, o_overflow<=1.
- o_overflow: set by a drop event, cleared by i_clear_overflow. If both occur in the same cycle, set wins.
- o_full, o_empty, o_count are derived from the registered count, with no combinational path from inputs.
- No state machine beyond pointer/count; the count register disambiguates full vs empty.

Optional Feature:
- Macro UART_RX_FIFO_STATS_EN.
- Defined: adds output o_drop_count [7:0], reset 0, incremented on each dropped byte. It saturates at 255 and is cleared by i_clear_overflow. If a drop and a clear occur in the same cycle, result is 1. Also adds o_max_count [ADDR_W:0], the high-water mark of o_count, reset 0, cleared by i_clear_overflow to the current count.
- Undefined: neither port exists, no counters are synthesized, and the rest of the behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8
  - baud timing constants FULL_BIT=1395968 and HALF_BIT=697984, shared with the receiver and future transmitter
  - DEFAULT_RX_FIFO_DEPTH=16
- One natural sub-module, fifo_ptr_ctrl, owns the pointer/count/full/empty logic and is reusable for a future TX FIFO. Storage array and overflow logic stay in uart_rx_fifo.

Test Plan:
- Reset, then write 0x55 -> next cycle o_rd_valid=1, o_rd_data=0x55, o_count=1; pulse i_rd_ready -> o_empty=1, o_count=0.
- Write 0x00..0x0F (DEPTH=16) with i_rd_ready=0 -> o_full=1, o_count=16; read all 16 -> data 0x00..0x0F in order, pointers wrapped to 0.
- When full, write 0xAA with no read -> dropped, o_overflow=1, count stays 16; drain -> 0xAA never appears. With STATS_EN, o_drop_count=1.
- When full, write 0xBB with i_rd_ready=1 same cycle -> head popped, 0xBB accepted, count stays 16, o_overflow unchanged; 0xBB is read last.
- i_clear_overflow and a drop in the same cycle -> o_overflow remains 1; clear alone next cycle -> 0.
- Assert i_reset asynchronously between clock edges with count=5 -> o_empty=1, o_count=0 immediately; after release, write 0x3C -> read returns 0x3C.
